// File: rtl/fpu_agent_tag_buffer_if.sv
// Handshake bundle between FPU agent dispatch, the FPU core and the commit path,
// as seen by the tag buffer. The slave modport is the tag buffer's view.
interface fpu_agent_tag_buffer_if #(
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int UUID_W      = 44,
    parameter int NW_W        = 2,
    parameter int NR_W        = 6,
    parameter int DEPTH       = 4,
    localparam int TAG_W      = $clog2(DEPTH)
);
    logic                        req_valid;
    logic [UUID_W-1:0]           req_uuid;
    logic [NW_W-1:0]             req_wid;
    logic [NUM_THREADS-1:0]      req_tmask;
    logic [XLEN-1:0]             req_PC;
    logic [NR_W-1:0]             req_rd;
    logic                        req_ready;

    logic                        fpu_req_valid;
    logic [TAG_W-1:0]            fpu_req_tag;
    logic                        fpu_req_ready;

    logic                        fpu_rsp_valid;
    logic [TAG_W-1:0]            fpu_rsp_tag;
    logic [NUM_THREADS*XLEN-1:0] fpu_rsp_data;
    logic [4:0]                  fpu_rsp_fflags;
    logic                        fpu_rsp_ready;

    logic                        cmt_valid;
    logic [UUID_W-1:0]           cmt_uuid;
    logic [NW_W-1:0]             cmt_wid;
    logic [NUM_THREADS-1:0]      cmt_tmask;
    logic [XLEN-1:0]             cmt_PC;
    logic [NR_W-1:0]             cmt_rd;
    logic [NUM_THREADS*XLEN-1:0] cmt_data;
    logic [4:0]                  cmt_fflags;
    logic                        cmt_ready;

    modport slave (
        input  req_valid, req_uuid, req_wid, req_tmask, req_PC, req_rd,
        output req_ready,
        output fpu_req_valid, fpu_req_tag,
        input  fpu_req_ready,
        input  fpu_rsp_valid, fpu_rsp_tag, fpu_rsp_data, fpu_rsp_fflags,
        output fpu_rsp_ready,
        output cmt_valid, cmt_uuid, cmt_wid, cmt_tmask, cmt_PC, cmt_rd, cmt_data, cmt_fflags,
        input  cmt_ready
    );

    modport master (
        output req_valid, req_uuid, req_wid, req_tmask, req_PC, req_rd,
        input  req_ready,
        input  fpu_req_valid, fpu_req_tag,
        output fpu_req_ready,
        output fpu_rsp_valid, fpu_rsp_tag, fpu_rsp_data, fpu_rsp_fflags,
        input  fpu_rsp_ready,
        input  cmt_valid, cmt_uuid, cmt_wid, cmt_tmask, cmt_PC, cmt_rd, cmt_data, cmt_fflags,
        output cmt_ready
    );
endinterface

// File: rtl/fpu_agent_tag_buffer.sv
// Tag table that parks request commit metadata while the FPU core works, then rejoins
// it with out-of-order tagged results into a registered commit packet.
module fpu_agent_tag_buffer #(
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int UUID_W      = 44,
    parameter int NW_W        = 2,
    parameter int NR_W        = 6,
    parameter int DEPTH       = 4,
    localparam int TAG_W      = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    fpu_agent_tag_buffer_if.slave  bus,
    output logic [CNT_W-1:0]       pending,
    output logic                   full,
    output logic                   err_orphan
);
    logic [UUID_W-1:0]      uuid_mem  [DEPTH];
    logic [NW_W-1:0]        wid_mem   [DEPTH];
    logic [NUM_THREADS-1:0] tmask_mem [DEPTH];
    logic [XLEN-1:0]        pc_mem    [DEPTH];
    logic [NR_W-1:0]        rd_mem    [DEPTH];

    logic [DEPTH-1:0]       alloc_mask_reg, alloc_mask_next;
    logic [DEPTH-1:0]       alloc_onehot, release_onehot;
    logic [CNT_W-1:0]       pending_reg, pending_next;
    logic                   err_orphan_reg;
    logic                   cmt_valid_reg;
    logic [UUID_W-1:0]      cmt_uuid_reg;
    logic [NW_W-1:0]        cmt_wid_reg;
    logic [NUM_THREADS-1:0] cmt_tmask_reg;
    logic [XLEN-1:0]        cmt_pc_reg;
    logic [NR_W-1:0]        cmt_rd_reg;
    logic [NUM_THREADS*XLEN-1:0] cmt_data_reg;
    logic [4:0]             cmt_fflags_reg;

    logic [TAG_W-1:0]       free_tag;
    logic                   full_int;
    logic                   do_alloc, rsp_accept, rsp_hit, rsp_orphan;

    // Descending scan so the last match written is the lowest free index.
    always_comb begin
        free_tag = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!alloc_mask_reg[i]) free_tag = TAG_W'(i);
        end
    end

    assign full_int          = (pending_reg == CNT_W'(DEPTH));
    assign bus.fpu_req_valid = bus.req_valid & ~full_int;
    assign bus.req_ready     = bus.fpu_req_ready & ~full_int;
    assign bus.fpu_req_tag   = free_tag;
    assign do_alloc          = bus.req_valid & bus.req_ready;

    assign bus.fpu_rsp_ready = ~cmt_valid_reg | bus.cmt_ready;
    assign rsp_accept        = bus.fpu_rsp_valid & bus.fpu_rsp_ready;
    assign rsp_hit           = rsp_accept & alloc_mask_reg[bus.fpu_rsp_tag];
    assign rsp_orphan        = rsp_accept & ~alloc_mask_reg[bus.fpu_rsp_tag];

    // Alloc and release never target the same slot: alloc picks a clear bit, release a set one.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign alloc_onehot[gi]   = do_alloc & (free_tag == TAG_W'(gi));
            assign release_onehot[gi] = rsp_hit & (bus.fpu_rsp_tag == TAG_W'(gi));
        end
    endgenerate

    assign alloc_mask_next = (alloc_mask_reg | alloc_onehot) & ~release_onehot;

    always_comb begin
        pending_next = pending_reg;
        if (do_alloc && !rsp_hit)      pending_next = pending_reg + CNT_W'(1);
        else if (!do_alloc && rsp_hit) pending_next = pending_reg - CNT_W'(1);
    end

    // Metadata storage is guarded by alloc_mask, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            uuid_mem[free_tag]  <= bus.req_uuid;
            wid_mem[free_tag]   <= bus.req_wid;
            tmask_mem[free_tag] <= bus.req_tmask;
            pc_mem[free_tag]    <= bus.req_PC;
            rd_mem[free_tag]    <= bus.req_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc_mask_reg <= '0;
            pending_reg    <= '0;
            err_orphan_reg <= 1'b0;
            cmt_valid_reg  <= 1'b0;
            cmt_uuid_reg   <= '0;
            cmt_wid_reg    <= '0;
            cmt_tmask_reg  <= '0;
            cmt_pc_reg     <= '0;
            cmt_rd_reg     <= '0;
            cmt_data_reg   <= '0;
            cmt_fflags_reg <= '0;
        end else begin
            alloc_mask_reg <= alloc_mask_next;
            pending_reg    <= pending_next;
            if (rsp_orphan) err_orphan_reg <= 1'b1;
            if (rsp_hit) begin
                cmt_valid_reg  <= 1'b1;
                cmt_uuid_reg   <= uuid_mem[bus.fpu_rsp_tag];
                cmt_wid_reg    <= wid_mem[bus.fpu_rsp_tag];
                cmt_tmask_reg  <= tmask_mem[bus.fpu_rsp_tag];
                cmt_pc_reg     <= pc_mem[bus.fpu_rsp_tag];
                cmt_rd_reg     <= rd_mem[bus.fpu_rsp_tag];
                cmt_data_reg   <= bus.fpu_rsp_data;
                cmt_fflags_reg <= bus.fpu_rsp_fflags;
            end else if (bus.cmt_ready) begin
                cmt_valid_reg  <= 1'b0;
            end
        end
    end

    assign bus.cmt_valid  = cmt_valid_reg;
    assign bus.cmt_uuid   = cmt_uuid_reg;
    assign bus.cmt_wid    = cmt_wid_reg;
    assign bus.cmt_tmask  = cmt_tmask_reg;
    assign bus.cmt_PC     = cmt_pc_reg;
    assign bus.cmt_rd     = cmt_rd_reg;
    assign bus.cmt_data   = cmt_data_reg;
    assign bus.cmt_fflags = cmt_fflags_reg;
    assign pending        = pending_reg;
    assign full           = full_int;
    assign err_orphan     = err_orphan_reg;
endmodule

// File: tb/tb_fpu_agent_tag_buffer.sv
// Directed bench for the FPU agent tag buffer: allocation order, out-of-order rejoin,
// backpressure, same-cycle alloc/release, orphan detection and asynchronous reset.
module tb_fpu_agent_tag_buffer;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] pending;
    logic       full;
    logic       err_orphan;
    int         checks = 0;
    int         failures = 0;

    fpu_agent_tag_buffer_if #(.NUM_THREADS(4), .XLEN(32), .UUID_W(44), .NW_W(2), .NR_W(6), .DEPTH(4)) bus ();

    fpu_agent_tag_buffer #(.NUM_THREADS(4), .XLEN(32), .UUID_W(44), .NW_W(2), .NR_W(6), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .pending    (pending),
        .full       (full),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Entered just after a falling edge; returns just after the next falling edge.
    task automatic send_req(input logic [43:0] uuid, input logic [1:0] wid, input logic [3:0] tmask,
                            input logic [31:0] pc, input logic [5:0] rd, input logic [1:0] exp_tag);
        bus.req_valid = 1'b1;
        bus.req_uuid  = uuid;
        bus.req_wid   = wid;
        bus.req_tmask = tmask;
        bus.req_PC    = pc;
        bus.req_rd    = rd;
        #1;
        check($sformatf("req_tag_uuid%0d", uuid), bus.fpu_req_tag, exp_tag);
        check($sformatf("req_ready_uuid%0d", uuid), bus.req_ready, 1'b1);
        $display("req  uuid=%0d tag=%0d", uuid, bus.fpu_req_tag);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic send_rsp(input logic [1:0] tag, input logic [127:0] data, input logic [4:0] fflags);
        bus.fpu_rsp_valid  = 1'b1;
        bus.fpu_rsp_tag    = tag;
        bus.fpu_rsp_data   = data;
        bus.fpu_rsp_fflags = fflags;
        #1;
        check($sformatf("rsp_ready_tag%0d", tag), bus.fpu_rsp_ready, 1'b1);
        @(negedge clk);
        bus.fpu_rsp_valid = 1'b0;
        $display("rsp  tag=%0d -> cmt_valid=%0b cmt_uuid=%0d pending=%0d", tag, bus.cmt_valid, bus.cmt_uuid, pending);
    endtask

    initial begin
        bus.req_valid      = 1'b0;
        bus.req_uuid       = '0;
        bus.req_wid        = '0;
        bus.req_tmask      = '0;
        bus.req_PC         = '0;
        bus.req_rd         = '0;
        bus.fpu_req_ready  = 1'b1;
        bus.fpu_rsp_valid  = 1'b0;
        bus.fpu_rsp_tag    = '0;
        bus.fpu_rsp_data   = '0;
        bus.fpu_rsp_fflags = '0;
        bus.cmt_ready      = 1'b1;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_pending", pending, 0);
        check("rst_full", full, 0);
        check("rst_cmt_valid", bus.cmt_valid, 0);
        check("rst_err_orphan", err_orphan, 0);
        check("rst_req_tag", bus.fpu_req_tag, 0);
        check("rst_cmt_uuid", bus.cmt_uuid, 0);
        @(negedge clk);

        // Single op
        send_req(44'd5, 2'd1, 4'b1011, 32'h100, 6'd7, 2'd0);
        check("single_pending1", pending, 1);
        send_rsp(2'd0, {4{32'h3F800000}}, 5'h01);
        check("single_cmt_valid", bus.cmt_valid, 1);
        check("single_uuid", bus.cmt_uuid, 5);
        check("single_wid", bus.cmt_wid, 1);
        check("single_tmask", bus.cmt_tmask, 4'b1011);
        check("single_pc", bus.cmt_PC, 32'h100);
        check("single_rd", bus.cmt_rd, 7);
        check("single_data", bus.cmt_data, {4{32'h3F800000}});
        check("single_fflags", bus.cmt_fflags, 5'h01);
        check("single_pending0", pending, 0);
        @(negedge clk);
        check("single_cmt_drop", bus.cmt_valid, 0);

        // Fill then out-of-order return 2,0,3,1
        for (int i = 0; i < 4; i++) send_req(44'(10 + i), 2'(i), 4'hF, 32'(i), 6'(i), 2'(i));
        check("fill_full", full, 1);
        check("fill_pending", pending, 4);
        bus.req_valid = 1'b1;
        #1;
        check("fill_req_ready", bus.req_ready, 0);
        check("fill_fpu_req_valid", bus.fpu_req_valid, 0);
        check("fill_tag_zero", bus.fpu_req_tag, 0);
        bus.req_valid = 1'b0;
        send_rsp(2'd2, 128'h2, 5'h0);
        check("ooo_uuid_t2", bus.cmt_uuid, 12);
        check("ooo_full_drop", full, 0);
        check("ooo_pending3", pending, 3);
        send_rsp(2'd0, 128'h0, 5'h0);
        check("ooo_uuid_t0", bus.cmt_uuid, 10);
        send_rsp(2'd3, 128'h3, 5'h0);
        check("ooo_uuid_t3", bus.cmt_uuid, 13);
        send_rsp(2'd1, 128'h1, 5'h0);
        check("ooo_uuid_t1", bus.cmt_uuid, 11);
        check("ooo_valid_last", bus.cmt_valid, 1);
        check("ooo_pending0", pending, 0);
        @(negedge clk);

        // Backpressure
        send_req(44'd20, 2'd0, 4'h1, 32'h20, 6'd1, 2'd0);
        send_req(44'd21, 2'd0, 4'h2, 32'h21, 6'd2, 2'd1);
        bus.cmt_ready = 1'b0;
        send_rsp(2'd1, 128'h21, 5'h2);
        check("bp_first_uuid", bus.cmt_uuid, 21);
        bus.fpu_rsp_valid = 1'b1;
        bus.fpu_rsp_tag   = 2'd0;
        bus.fpu_rsp_data  = 128'h20;
        #1;
        check("bp_rsp_ready_low", bus.fpu_rsp_ready, 0);
        @(negedge clk);
        check("bp_hold_valid", bus.cmt_valid, 1);
        check("bp_hold_uuid", bus.cmt_uuid, 21);
        check("bp_hold_data", bus.cmt_data, 128'h21);
        check("bp_hold_pending", pending, 1);
        bus.cmt_ready = 1'b1;
        #1;
        check("bp_rsp_ready_high", bus.fpu_rsp_ready, 1);
        @(negedge clk);
        bus.fpu_rsp_valid = 1'b0;
        check("bp_second_valid", bus.cmt_valid, 1);
        check("bp_second_uuid", bus.cmt_uuid, 20);
        $display("bp   second commit uuid=%0d", bus.cmt_uuid);
        @(negedge clk);
        check("bp_drain", bus.cmt_valid, 0);
        check("bp_pending0", pending, 0);

        // Same-cycle alloc and release
        send_req(44'd30, 2'd0, 4'h1, 32'h30, 6'd3, 2'd0);
        send_req(44'd31, 2'd0, 4'h1, 32'h31, 6'd3, 2'd1);
        bus.req_valid     = 1'b1;
        bus.req_uuid      = 44'd32;
        bus.fpu_rsp_valid = 1'b1;
        bus.fpu_rsp_tag   = 2'd0;
        #1;
        check("same_new_tag", bus.fpu_req_tag, 2);
        @(negedge clk);
        bus.req_valid     = 1'b0;
        bus.fpu_rsp_valid = 1'b0;
        check("same_pending", pending, 2);
        check("same_cmt_uuid", bus.cmt_uuid, 30);
        $display("same alloc tag=2 release tag=0 pending=%0d", pending);
        send_rsp(2'd1, 128'h0, 5'h0);
        check("same_rel_t1", bus.cmt_uuid, 31);
        send_rsp(2'd2, 128'h0, 5'h0);
        check("same_rel_t2", bus.cmt_uuid, 32);
        check("same_pending0", pending, 0);

        // Orphan
        send_req(44'd40, 2'd0, 4'h1, 32'h40, 6'd4, 2'd0);
        send_rsp(2'd3, 128'hDEAD, 5'h1F);
        check("orphan_flag", err_orphan, 1);
        check("orphan_no_commit", bus.cmt_valid, 0);
        check("orphan_payload_kept", bus.cmt_uuid, 32);
        check("orphan_pending", pending, 1);

        // Reset mid-flight with three tags pending and a held commit
        send_req(44'd41, 2'd0, 4'h1, 32'h41, 6'd4, 2'd1);
        send_req(44'd42, 2'd0, 4'h1, 32'h42, 6'd4, 2'd2);
        bus.cmt_ready = 1'b0;
        send_rsp(2'd0, 128'h40, 5'h0);
        send_req(44'd43, 2'd0, 4'h1, 32'h43, 6'd4, 2'd0);
        check("pre_rst_pending", pending, 3);
        check("pre_rst_held", bus.cmt_uuid, 40);
        reset = 1'b1;
        #1;
        check("arst_pending", pending, 0);
        check("arst_full", full, 0);
        check("arst_cmt_valid", bus.cmt_valid, 0);
        check("arst_cmt_uuid", bus.cmt_uuid, 0);
        check("arst_err_orphan", err_orphan, 0);
        check("arst_req_tag", bus.fpu_req_tag, 0);
        $display("rst  asserted mid-flight pending=%0d cmt_valid=%0b", pending, bus.cmt_valid);
        #2;
        reset = 1'b0;
        bus.cmt_ready = 1'b1;
        @(negedge clk);
        send_req(44'd50, 2'd0, 4'h1, 32'h50, 6'd5, 2'd0);
        send_rsp(2'd2, 128'h0, 5'h0);
        check("post_rst_orphan", err_orphan, 1);
        check("post_rst_no_commit", bus.cmt_valid, 0);
        check("post_rst_pending", pending, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
